// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit with architectural HI/LO and a modelled multi-cycle busy window.
// Define MULT_DIV_MADD_EN to add madd/maddu (MDOp 9/10) accumulating into {HI,LO}.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] MDOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [63:0] temp;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] result;
  logic        accept;
  logic [3:0]  load_cycles;

  // Signed divide on magnitudes so truncation and remainder sign never depend on
  // simulator handling of negative operands; 0x80000000 / -1 wraps to 0x80000000.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    return {a % b, a / b};
  endfunction

  always_comb begin
    prod_s      = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u      = {32'b0, A} * {32'b0, B};
    result      = {HI, LO};
    accept      = 1'b0;
    load_cycles = 4'(MULT_CYCLES);
    case (MDOp)
      4'd1: begin
        result = prod_s;
        accept = 1'b1;
      end
      4'd2: begin
        result = prod_u;
        accept = 1'b1;
      end
      4'd3: begin
        accept      = 1'b1;
        load_cycles = 4'(DIV_CYCLES);
        // Divide by zero keeps the current HI/LO so the result write is a no-op.
        if (B != 32'b0) result = div_signed(A, B);
      end
      4'd4: begin
        accept      = 1'b1;
        load_cycles = 4'(DIV_CYCLES);
        if (B != 32'b0) result = div_unsigned(A, B);
      end
`ifdef MULT_DIV_MADD_EN
      4'd9: begin
        result = {HI, LO} + prod_s;
        accept = 1'b1;
      end
      4'd10: begin
        result = {HI, LO} + prod_u;
        accept = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      count <= 4'd0;
      temp  <= 64'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && accept) begin
            temp  <= result;
            count <= load_cycles;
            Busy  <= 1'b1;
            state <= BUSY;
          end else if (!Start && MDOp == 4'd7) begin
            HI <= A;
          end else if (!Start && MDOp == 4'd8) begin
            LO <= A;
          end
        end
        BUSY: begin
          // Start, mthi and mtlo are all ignored here; only the countdown advances.
          if (count <= 4'd1) begin
            {HI, LO} <= temp;
            Busy     <= 1'b0;
            count    <= 4'd0;
            state    <= IDLE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    case (MDOp)
      4'd5:    MDOut = HI;
      4'd6:    MDOut = LO;
      default: MDOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table through a scoreboard queue,
// plus hand sequences for mthi/mtlo, ignored Start, async reset and madd.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A, B;
  logic        Busy;
  logic [31:0] MDOut, HI, LO;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[11];

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
    .Busy(Busy), .MDOut(MDOut), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pulse Start for one cycle; returns at the negedge of busy cycle 1.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MDOp = op; A = a; B = b;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input int n);
    exp_t e;
    e.hi = hi; e.lo = lo; e.n = n;
    sb.push_back(e);
    drive(op, a, b);
  endtask

  task automatic finish_op(input string name, input int already);
    int   cnt;
    exp_t e;
    cnt = already;
    while (Busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL %s_scoreboard: got empty queue expected entry", name);
      return;
    end
    e = sb.pop_front();
    check({name, "_busy_cycles"}, cnt, e.n);
    check({name, "_hi"}, HI, e.hi);
    check({name, "_lo"}, LO, e.lo);
    MDOp = 4'd5; #1;
    check({name, "_mfhi"}, MDOut, e.hi);
    MDOp = 4'd6; #1;
    check({name, "_mflo"}, MDOut, e.lo);
    MDOp = 4'd0; #1;
  endtask

  task automatic move_to(input logic [3:0] op, input logic [31:0] a);
    MDOp = op; A = a;
    @(negedge clk);
    MDOp = 4'd0; A = 32'd0;
  endtask

  initial begin
    int  busy_seen;
    vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[2]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[3]  = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[4]  = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[5]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[6]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[8]  = '{4'd2, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5};
    vecs[9]  = '{4'd4, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF, 10};
    vecs[10] = '{4'd3, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 10};

    reset = 1'b1; Start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", Busy, 1'b0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].n);
      finish_op($sformatf("vec%0d", i), 0);
      @(negedge clk);
    end

    MDOp = 4'd1; #1;
    check("mdout_other_op", MDOut, 32'd0);
    MDOp = 4'd0;

    // mthi/mtlo, then divide by zero leaves them intact
    move_to(4'd7, 32'h1234);
    move_to(4'd8, 32'h5678);
    check("mthi", HI, 32'h1234);
    check("mtlo", LO, 32'h5678);
    start_op(4'd4, 32'd100, 32'd0, 32'h1234, 32'h5678, 10);
    finish_op("divu_by_zero", 0);

    // mthi with Start raised on a non-MD op is not a move
    Start = 1'b1; MDOp = 4'd7; A = 32'hDEAD;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0;
    check("mthi_with_start", HI, 32'h1234);

    // mthi and second Start during busy are ignored
    start_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
    MDOp = 4'd7; A = 32'hAAAA;
    @(negedge clk);
    Start = 1'b1; MDOp = 4'd1; A = 32'd5; B = 32'd5;
    @(negedge clk);
    Start = 1'b0; MDOp = 4'd0; A = 32'd0; B = 32'd0;
    finish_op("ignored_during_busy", 2);
    @(negedge clk);
    check("no_restart_busy", Busy, 1'b0);

    // async reset mid-operation
    drive(4'd1, 32'd3, 32'd3);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", Busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_busy", Busy, 1'b0);
    check("async_reset_hi", HI, 32'd0);
    check("async_reset_lo", LO, 32'd0);
    #1 reset = 1'b0;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (Busy) busy_seen++;
    end
    check("post_reset_busy_cycles", busy_seen, 0);
    check("post_reset_hi", HI, 32'd0);
    check("post_reset_lo", LO, 32'd0);

    // accumulate ops
    move_to(4'd8, 32'hFFFFFFFF);
    move_to(4'd7, 32'h0);
`ifdef MULT_DIV_MADD_EN
    start_op(4'd10, 32'd1, 32'd1, 32'h00000001, 32'h00000000, 5);
    finish_op("maddu_carry", 0);
    @(negedge clk);
    start_op(4'd9, 32'hFFFFFFFF, 32'd2, 32'h00000000, 32'hFFFFFFFE, 5);
    finish_op("madd_signed", 0);
`else
    drive(4'd10, 32'd1, 32'd1);
    busy_seen = 0;
    repeat (6) begin
      if (Busy) busy_seen++;
      @(negedge clk);
    end
    check("maddu_disabled_busy", busy_seen, 0);
    check("maddu_disabled_hi", HI, 32'h0);
    check("maddu_disabled_lo", LO, 32'hFFFFFFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Execute-stage multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline.
- Takes forwarded operands from the E-stage forwarding muxes and models multi-cycle latency.
- Exports Start/Busy to the hazard unit, which stalls any MD-class instruction in D while Start||Busy.
- Drives MDOut into the E/M result path for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (and madd-class when enabled); legal range 1..15.
- DIV_CYCLES, 10, Busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- Start  input  1  E-stage instruction is mult/multu/div/divu (or madd-class); one-cycle pulse per instruction.
- MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu; 11-15 are no-op.
- A  input  32  forwarded rs value (E stage).
- B  input  32  forwarded rt value (E stage).
- Busy  output  1  registered; high while an operation is in flight.
- MDOut  output  32  combinational; HI if MDOp==5, LO if MDOp==6, else 0.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset (async) state: Busy=0, HI=0, LO=0, counter=0, temp result=0, state IDLE.
- Two-state FSM: IDLE and BUSY.
- IDLE -> BUSY:
  - Triggered on a clk edge with Start=1 and MDOp in {1,2,3,4} (or {9,10} with MADD_EN).
  - Latches the computed {HI,LO} result into a 64-bit temp.
  - Loads counter with MULT_CYCLES or DIV_CYCLES; Busy goes 1 from the next cycle.
- BUSY:
  - Counter decrements each edge.
  - On the edge where counter==1: HI/LO <= temp, Busy <= 0, state -> IDLE.
  - Busy is therefore high for exactly N cycles following the Start cycle; new HI/LO are visible the cycle after Busy falls.
- Arithmetic:
  - mult: signed 32x32 -> 64, HI = upper word, LO = lower word.
  - multu: unsigned 32x32 -> 64.
  - div: signed, quotient truncates toward zero -> LO; remainder takes the sign of the dividend -> HI.
  - divu: unsigned.
  - Overflow case 0x80000000 / 0xFFFFFFFF (div): LO=0x80000000, HI=0.
- Divide by zero (B==0):
  - Still occupies DIV_CYCLES of Busy.
  - HI/LO unchanged at completion; no X may propagate.
- mthi/mtlo (MDOp 7/8):
  - Write A into HI/LO at the next edge when IDLE and Start=0; Start is not required.
  - Ignored when Busy=1.
- Start while Busy=1: ignored, and the in-flight operation is unaffected. The hazard unit prevents this; the bench checks it anyway.
- MDOut is purely combinational from the current HI/LO. The hazard unit guarantees mfhi/mflo never reach E while Busy or Start.
- Start and MDOp 7/8 in the same cycle: the Start decode wins, since the MDOp value selects only one op.
- Reset mid-operation: the pending result is discarded; HI/LO=0, Busy=0 immediately, without waiting for clk.

Optional Feature:
- Macro: MULT_DIV_MADD_EN.
- Defined:
  - MDOp 9 (madd) computes {HI,LO} + signed(A*B).
  - MDOp 10 (maddu) computes {HI,LO} + unsigned(A*B), with 64-bit wraparound.
  - Both use the HI/LO values sampled at the Start edge and take MULT_CYCLES.
- Undefined: MDOp 9/10 are no-ops; Start with them does not assert Busy; no accumulator adder is synthesized.

Test Plan:
- Reset, then Start, MDOp=1, A=0xFFFFFFFE (-2), B=3:
  - Busy high for exactly 5 cycles.
  - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - mfhi/mflo via MDOut return the same values.
- Start, MDOp=3, A=-7 (0xFFFFFFF9), B=2:
  - Busy for 10 cycles.
  - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- divu with A=100, B=0 after mthi A=0x1234, mtlo A=0x5678:
  - Busy for 10 cycles.
  - HI=0x1234 and LO=0x5678 unchanged.
- Start multu A=0xFFFFFFFF, B=0xFFFFFFFF, then MDOp=7 with A=0xAAAA at cycle 2 and a second Start at cycle 3:
  - Both ignored.
  - Final HI=0xFFFFFFFE, LO=0x00000001.
- Start mult, assert reset asynchronously mid-cycle at Busy cycle 3:
  - Busy, HI, LO drop to 0 before the next clk edge.
  - No update after reset releases.
- With MULT_DIV_MADD_EN: mtlo 0xFFFFFFFF, mthi 0, then maddu A=1, B=1:
  - After 5 Busy cycles HI=1, LO=0.
  - Without the macro, Busy stays 0 and HI/LO are unchanged.
